// File: rtl/rmw_counter_mem.sv
// Counter memory: two-stage read-modify-write increment with S1 forwarding,
// a write-first registered read port and a post-reset clear sweep.
module rmw_counter_mem #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_inc_valid,
    input  logic [ADDR_W-1:0] io_inc_addr,
    input  logic [DATA_W-1:0] io_inc_delta,
    output logic              io_ready,
    input  logic [ADDR_W-1:0] io_rd_addr,
    output logic [DATA_W-1:0] io_rd_data,
    output logic              io_overflow
);

    // Handshake: a request transfers on any rising edge where io_inc_valid and
    // io_ready are both high; io_ready depends only on state, never on valid.
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic              clr_en;
    logic              accept;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_delta;
    logic [DATA_W-1:0] s1_op;

    logic [DATA_W:0]   sum;
    logic              carry;
    logic [DATA_W-1:0] wr_val;
    logic              commit;
    logic [DATA_W-1:0] fwd_op;
    logic [DATA_W-1:0] rd_next;

    always_comb begin
        state_d  = state_q;
        io_ready = 1'b0;
        clr_en   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN:   io_ready = 1'b1;
            default:  state_d = ST_CLEAR;
        endcase
    end

    assign accept = io_inc_valid && io_ready;
    assign commit = s1_valid;
    assign sum    = {1'b0, s1_op} + {1'b0, s1_delta};
    assign carry  = sum[DATA_W];
    assign wr_val = ((SATURATE != 0) && carry) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];

    // The entry being committed this edge is newer than the array copy.
    assign fwd_op  = (commit && (s1_addr == io_inc_addr)) ? wr_val : mem[io_inc_addr];
    assign rd_next = (commit && (s1_addr == io_rd_addr))  ? wr_val : mem[io_rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            s1_valid    <= 1'b0;
            io_overflow <= 1'b0;
            io_rd_data  <= '0;
        end else begin
            state_q     <= state_d;
            if (clr_en) clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
            s1_valid    <= accept;
            io_overflow <= commit && carry;
            io_rd_data  <= clr_en ? '0 : rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr  <= io_inc_addr;
            s1_delta <= io_inc_delta;
            s1_op    <= fwd_op;
        end
    end

    // Sweep and commit never overlap: nothing is accepted until the sweep ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en)
                mem[clr_ptr_q] <= '0;
            else if (commit)
                mem[s1_addr] <= wr_val;
        end
    end

endmodule

// File: tb/tb_rmw_counter_mem.sv
// Directed bench for rmw_counter_mem: a wrapping and a saturating instance
// (DATA_W=8, DEPTH=8) share one stimulus stream.
module tb_rmw_counter_mem;

    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          inc_valid = 1'b0;
    logic [AW-1:0] inc_addr = '0;
    logic [DW-1:0] inc_delta = '0;
    logic [AW-1:0] rd_addr = '0;

    logic          ready0, ready1, ovf0, ovf1;
    logic [DW-1:0] rd0, rd1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rmw_counter_mem #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .SATURATE(0)) dut0 (
        .clk(clk), .reset(reset), .io_inc_valid(inc_valid), .io_inc_addr(inc_addr),
        .io_inc_delta(inc_delta), .io_ready(ready0), .io_rd_addr(rd_addr),
        .io_rd_data(rd0), .io_overflow(ovf0)
    );

    rmw_counter_mem #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .SATURATE(1)) dut1 (
        .clk(clk), .reset(reset), .io_inc_valid(inc_valid), .io_inc_addr(inc_addr),
        .io_inc_delta(inc_delta), .io_ready(ready1), .io_rd_addr(rd_addr),
        .io_rd_data(rd1), .io_overflow(ovf1)
    );

    // Called at a negedge; returns the registered read data one edge later.
    task automatic read_entry(input int a, output logic [DW-1:0] d0, output logic [DW-1:0] d1);
        rd_addr = AW'(a);
        @(negedge clk);
        d0 = rd0;
        d1 = rd1;
    endtask

    // Holds reset two edges, releases it and checks the 8-cycle sweep window.
    task automatic reset_and_sweep(input string tag);
        logic [DW-1:0] d0, d1;
        reset     = 1'b1;
        inc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({ready0, ready1, ovf0, ovf1} !== 4'b0000 || rd0 !== 8'd0 || rd1 !== 8'd0) begin
            bad++;
            $display("FAIL %s_in_reset: ready=%b%b ovf=%b%b rd=%0d/%0d, required all zero",
                     tag, ready0, ready1, ovf0, ovf1, rd0, rd1);
        end
        reset = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            total++;
            if (ready0 !== 1'b0 || ready1 !== 1'b0 || rd0 !== 8'd0) begin
                bad++;
                $display("FAIL %s_sweep_low[%0d]: ready=%b%b rd=%0d, required ready=00 rd=0",
                         tag, i, ready0, ready1, rd0);
            end
            @(negedge clk);
        end
        total++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            bad++;
            $display("FAIL %s_sweep_done: ready=%b%b, required 11", tag, ready0, ready1);
            // Bounded wait so later tests still get a usable DUT.
            for (int i = 0; i < 20 && !(ready0 && ready1); i++) @(negedge clk);
        end
        for (int a = 0; a < DEP; a++) begin
            read_entry(a, d0, d1);
            total++;
            if (d0 !== 8'd0 || d1 !== 8'd0) begin
                bad++;
                $display("FAIL %s_cleared[%0d]: got %0d/%0d, required 0", tag, a, d0, d1);
            end
        end
    endtask

    task automatic test_reset();
        reset_and_sweep("reset");
    endtask

    task automatic test_hazard();
        logic [DW-1:0] d0, d1;
        logic [DW-1:0] exp_v;
        rd_addr = 3'd3;
        for (int i = 0; i < 5; i++) begin
            inc_valid = 1'b1;
            inc_addr  = 3'd3;
            inc_delta = 8'd1;
            @(negedge clk);
        end
        inc_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rd0 !== 8'd5 || rd1 !== 8'd5) begin
            bad++;
            $display("FAIL hazard_latency: rd=%0d/%0d, required 5", rd0, rd1);
        end
        for (int a = 0; a < DEP; a++) begin
            exp_v = (a == 3) ? 8'd5 : 8'd0;
            read_entry(a, d0, d1);
            total++;
            if (d0 !== exp_v || d1 !== exp_v) begin
                bad++;
                $display("FAIL hazard_entry[%0d]: got %0d/%0d, required %0d", a, d0, d1, exp_v);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d0, d1;
        int p0, p1;
        p0 = 0;
        p1 = 0;
        inc_valid = 1'b1;
        inc_addr  = 3'd2;
        inc_delta = 8'd250;
        @(negedge clk);
        inc_delta = 8'd10;
        @(negedge clk);
        inc_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ovf0 === 1'b1) p0++;
            if (ovf1 === 1'b1) p1++;
            @(negedge clk);
        end
        total++;
        if (p0 != 1 || p1 != 1) begin
            bad++;
            $display("FAIL overflow_pulses: wrap=%0d sat=%0d, required 1 each", p0, p1);
        end
        read_entry(2, d0, d1);
        total++;
        if (d0 !== 8'd4) begin
            bad++;
            $display("FAIL overflow_wrap_value: got %0d, required 4", d0);
        end
        total++;
        if (d1 !== 8'd255) begin
            bad++;
            $display("FAIL overflow_sat_value: got %0d, required 255", d1);
        end
    endtask

    task automatic test_rd_commit();
        rd_addr   = 3'd6;
        inc_valid = 1'b1;
        inc_addr  = 3'd6;
        inc_delta = 8'd7;
        @(negedge clk);
        inc_valid = 1'b0;
        total++;
        if (rd0 !== 8'd0) begin
            bad++;
            $display("FAIL rd_commit_before: got %0d, required 0", rd0);
        end
        @(negedge clk);
        total++;
        if (rd0 !== 8'd7 || rd1 !== 8'd7) begin
            bad++;
            $display("FAIL rd_commit_same_edge: got %0d/%0d, required 7", rd0, rd1);
        end
    endtask

    task automatic test_interleave();
        logic [DW-1:0] d0, d1;
        int ovf_seen;
        ovf_seen = 0;
        for (int i = 0; i < 10; i++) begin
            inc_valid = 1'b1;
            inc_addr  = (i % 2 == 1) ? 3'd7 : 3'd0;
            inc_delta = 8'd2;
            @(negedge clk);
            if (ovf0 === 1'b1 || ovf1 === 1'b1) ovf_seen++;
        end
        inc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ovf0 === 1'b1 || ovf1 === 1'b1) ovf_seen++;
        end
        total++;
        if (ovf_seen != 0) begin
            bad++;
            $display("FAIL interleave_overflow: pulses=%0d, required 0", ovf_seen);
        end
        read_entry(0, d0, d1);
        total++;
        if (d0 !== 8'd10 || d1 !== 8'd10) begin
            bad++;
            $display("FAIL interleave_entry0: got %0d/%0d, required 10", d0, d1);
        end
        read_entry(7, d0, d1);
        total++;
        if (d0 !== 8'd10 || d1 !== 8'd10) begin
            bad++;
            $display("FAIL interleave_entry7: got %0d/%0d, required 10", d0, d1);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d0, d1;
        inc_valid = 1'b1;
        inc_addr  = 3'd1;
        inc_delta = 8'd3;
        @(negedge clk);
        @(negedge clk);
        // Second request is in flight and would commit on the next edge.
        reset_and_sweep("reset_mid");
        read_entry(1, d0, d1);
        total++;
        if (d0 !== 8'd0 || d1 !== 8'd0) begin
            bad++;
            $display("FAIL reset_mid_entry1: got %0d/%0d, required 0", d0, d1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hazard();
        test_overflow();
        test_rd_commit();
        test_interleave();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rmw_counter_mem.md
RMW_COUNTER_MEM -- requirements
Module: rmw_counter_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32: counter entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of entries, power of two, minimum 2.
REQ-003 SHALL have parameter ADDR_W, default log2(DEPTH) = 3: address width.
REQ-004 SHALL have parameter SATURATE, default 0: 0 wraps on overflow, 1 clamps to all-ones.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port io_inc_valid  input  1  increment request strobe.
REQ-008 SHALL have port io_inc_addr  input  ADDR_W  entry to increment.
REQ-009 SHALL have port io_inc_delta  input  DATA_W  unsigned amount to add.
REQ-010 SHALL have port io_ready  output  1  high when increment requests are accepted.
REQ-011 SHALL have port io_rd_addr  input  ADDR_W  read-port address.
REQ-012 SHALL have port io_rd_data  output  DATA_W  registered read data.
REQ-013 SHALL have port io_overflow  output  1  one-cycle pulse on an overflowing commit.

Function
REQ-014 SHALL hold DEPTH entries of DATA_W bits each.
REQ-015 SHALL accept a request on a cycle with io_inc_valid=1 and io_ready=1, with no backpressure once ready, sustaining one request per cycle.
REQ-016 SHALL ignore io_inc_valid while io_ready=0, with no side effects.
REQ-017 SHALL process an accepted request in 2 stages:
  - S1 (accept edge): register addr, delta and the operand (current entry value).
  - S2 (next edge): write operand+delta to the entry.
  - Commit latency: 2 edges after presentation.
REQ-018 SHALL forward on an S1 hazard: if S2 commits to the address accepted in the same cycle, the S1 operand SHALL be the S2 result, not the stale array value.
REQ-019 SHALL make N back-to-back increments of delta d to one address, starting from value v, yield v + N*d (modulo 2^DATA_W, or saturated).
REQ-020 SHALL compute the sum at DATA_W+1 bits:
  - Carry out = overflow.
  - SATURATE=0: write the low DATA_W bits.
  - SATURATE=1: write all-ones.
REQ-021 SHALL assert io_overflow during the cycle after the overflowing commit edge, for exactly one cycle per overflowing commit.
REQ-022 SHALL, on each edge, load io_rd_data with the value of entry io_rd_addr including any commit on that same edge (write-first).
REQ-023 SHALL keep the increment path independent of the read port; the read port SHALL never stall.
REQ-024 SHALL treat delta=0 as a normal request that rewrites the unchanged value and never overflows.

Reset
REQ-025 SHALL, on any edge with reset=1:
  - Drop any in-flight S1/S2 request without committing it.
  - Force io_ready=0, io_rd_data=0 and io_overflow=0.
  - Set the clear pointer to 0.
REQ-026 SHALL run a clear sweep after reset deasserts:
  - One entry is written to 0 per cycle, addresses 0..DEPTH-1.
  - io_ready rises on the cycle after entry DEPTH-1 is written.
  - The sweep takes exactly DEPTH cycles.
REQ-027 SHALL return 0 on io_rd_data during the sweep.
REQ-028 SHALL restart the sweep from address 0 on reset reassertion mid-sweep or mid-operation.
REQ-029 SHALL keep io_ready high from sweep completion until the next reset.

Verification
REQ-030 SHALL cover sweep timing: DEPTH=8, reset held 2 cycles then released -> io_ready low for exactly 8 cycles then high; reading every address returns 0.
REQ-031 SHALL cover hazard forwarding: 5 consecutive requests to addr 3, delta 1 -> entry 3 reads 5 two cycles after the last request; other entries remain 0.
REQ-032 SHALL cover overflow in both modes: DATA_W=8, entry 2 at 250, delta 10:
  - SATURATE=0 -> entry 2 = 4, one io_overflow pulse.
  - SATURATE=1 -> entry 2 = 255, one io_overflow pulse.
REQ-033 SHALL cover simultaneous read and commit: io_rd_addr=6 held while the request (6, delta 7) from 0 commits -> io_rd_data shows 7 on the commit edge, not a cycle later.
REQ-034 SHALL cover reset mid-operation: issue requests to addr 1, assert reset while one is in S2 -> after the new sweep entry 1 reads 0, and io_ready stays low for DEPTH cycles.
REQ-035 SHALL cover interleaving: alternating requests to addrs 0 and 7, delta 2, 10 cycles -> entries 0 and 7 each read 10; no io_overflow.
